// File: rtl/palindrome_pkg.sv
`default_nettype none
// ============================================================================
// Module      : palindrome_pkg
// Description : Shared types and elaboration-time helpers for the
//               palindrome checker. Provides the FSM state enum and the
//               width-derivation functions used by the top level.
// Revision    : 1.0 - initial release
// ============================================================================
package palindrome_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pal_state_e;

  // Number of significant digits of (2**width)-1 written in the given radix.
  function automatic int pal_max_digits(input int width, input int radix);
    longint unsigned v;
    int              n;
    if (width >= 64) v = '1;
    else             v = (64'd1 << width) - 64'd1;
    n = 1;
    if (radix >= 2) begin
      v = v / 64'(radix);
      while (v != 64'd0) begin
        n = n + 1;
        v = v / 64'(radix);
      end
    end
    return n;
  endfunction

  // The reversed value is below RADIX**MAX_DIGITS <= RADIX * 2**WIDTH,
  // so WIDTH + clog2(RADIX) bits always hold it without truncation.
  function automatic int pal_rev_w(input int width, input int radix);
    return width + $clog2(radix);
  endfunction

endpackage
`default_nettype wire

// File: rtl/digit_divmod.sv
`default_nettype none
// ============================================================================
// Module      : digit_divmod
// Description : Combinational single-digit extractor. Splits work_i into
//               work_i / RADIX and work_i % RADIX. Power-of-two radices
//               reduce to a shift and a mask.
// Ports       : work_i [WIDTH-1:0]  value to split
//               quot_o [WIDTH-1:0]  work_i / RADIX
//               rem_o  [REM_W-1:0]  work_i % RADIX (lowest digit)
// Revision    : 1.0 - initial release
// ============================================================================
module digit_divmod #(
  parameter  int WIDTH = 16,
  parameter  int RADIX = 10,
  localparam int REM_W = $clog2(RADIX)
) (
  input  logic [WIDTH-1:0] work_i,
  output logic [WIDTH-1:0] quot_o,
  output logic [REM_W-1:0] rem_o
);

  localparam bit c_IS_POW2 = ((RADIX & (RADIX - 1)) == 0);

  if (c_IS_POW2) begin : g_pow2
    assign quot_o = work_i >> REM_W;
    assign rem_o  = REM_W'(work_i);
  end else begin : g_div
    // Widen before dividing so the remainder slice exists even when the
    // digit is wider than the number itself.
    localparam int                 c_EXT_W     = WIDTH + REM_W;
    localparam logic [c_EXT_W-1:0] c_RADIX_EXT = c_EXT_W'(RADIX);
    logic [c_EXT_W-1:0] w_work_ext;
    assign w_work_ext = c_EXT_W'(work_i);
    assign quot_o     = WIDTH'(w_work_ext / c_RADIX_EXT);
    assign rem_o      = REM_W'(w_work_ext % c_RADIX_EXT);
  end

endmodule
`default_nettype wire

// File: rtl/palindrome_checker_seq.sv
`default_nettype none
// ============================================================================
// Module      : palindrome_checker_seq
// Description : Multi-cycle radix-RADIX palindrome checker. Consumes one
//               digit per cycle (lowest first), builds the digit-reversed
//               value and compares it with the original. Leading zeros are
//               not digits; 0 itself is one digit.
// Config      : PAL_REVERSE_OUT_EN - when defined, exposes reversed_num.
// Ports       : clk, rst           clock, synchronous active-high reset
//               in_valid/in_ready  input handshake, in_number [WIDTH-1:0]
//               out_valid/out_ready result handshake
//               is_palindrome      1 = palindrome
//               digit_count        significant digits [CNT_W-1:0]
//               reversed_num       final reversed value [REV_W-1:0] (opt.)
// Revision    : 1.0 - initial release
// ============================================================================
module palindrome_checker_seq
  import palindrome_pkg::*;
#(
  parameter  int WIDTH      = 16,
  parameter  int RADIX      = 10,
  localparam int MAX_DIGITS = pal_max_digits(WIDTH, RADIX),
  localparam int CNT_W      = $clog2(MAX_DIGITS + 1),
  localparam int REV_W      = pal_rev_w(WIDTH, RADIX)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_number,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             is_palindrome,
  output logic [CNT_W-1:0] digit_count
`ifdef PAL_REVERSE_OUT_EN
  ,
  output logic [REV_W-1:0] reversed_num
`endif
);

  if (WIDTH < 2 || RADIX < 2) begin : g_param_check
    $error("palindrome_checker_seq: WIDTH and RADIX must both be >= 2");
  end

  localparam int               c_REM_W     = $clog2(RADIX);
  localparam logic [REV_W-1:0] c_RADIX_REV = REV_W'(RADIX);

  pal_state_e       state_q, state_d;
  logic [WIDTH-1:0] orig_q, orig_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [REV_W-1:0] rev_q, rev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_pal_q, is_pal_d;
  logic [CNT_W-1:0] dcount_q, dcount_d;
`ifdef PAL_REVERSE_OUT_EN
  logic [REV_W-1:0] rev_out_q, rev_out_d;
`endif

  logic [WIDTH-1:0]   w_quot;
  logic [c_REM_W-1:0] w_rem;
  logic [REV_W-1:0]   w_rev_next;

  digit_divmod #(
    .WIDTH (WIDTH),
    .RADIX (RADIX)
  ) u_divmod (
    .work_i (work_q),
    .quot_o (w_quot),
    .rem_o  (w_rem)
  );

  assign w_rev_next = rev_q * c_RADIX_REV + REV_W'(w_rem);

  always_comb begin
    state_d  = state_q;
    orig_d   = orig_q;
    work_d   = work_q;
    rev_d    = rev_q;
    cnt_d    = cnt_q;
    is_pal_d = is_pal_q;
    dcount_d = dcount_q;
`ifdef PAL_REVERSE_OUT_EN
    rev_out_d = rev_out_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          orig_d  = in_number;
          work_d  = in_number;
          rev_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        rev_d  = w_rev_next;
        work_d = w_quot;
        cnt_d  = cnt_q + CNT_W'(1);
        // Last significant digit consumed: result is final this edge.
        if (w_quot == '0) begin
          is_pal_d = (w_rev_next == REV_W'(orig_q));
          dcount_d = cnt_q + CNT_W'(1);
          state_d  = DONE;
`ifdef PAL_REVERSE_OUT_EN
          rev_out_d = w_rev_next;
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      orig_q   <= '0;
      work_q   <= '0;
      rev_q    <= '0;
      cnt_q    <= '0;
      is_pal_q <= 1'b0;
      dcount_q <= '0;
`ifdef PAL_REVERSE_OUT_EN
      rev_out_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      orig_q   <= orig_d;
      work_q   <= work_d;
      rev_q    <= rev_d;
      cnt_q    <= cnt_d;
      is_pal_q <= is_pal_d;
      dcount_q <= dcount_d;
`ifdef PAL_REVERSE_OUT_EN
      rev_out_q <= rev_out_d;
`endif
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign is_palindrome = is_pal_q;
  assign digit_count   = dcount_q;
`ifdef PAL_REVERSE_OUT_EN
  assign reversed_num  = rev_out_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_palindrome_checker_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_palindrome_checker_seq
// Description : Self-checking bench for palindrome_checker_seq. Instance A
//               uses default parameters (16-bit, radix 10); instance B uses
//               WIDTH=8, RADIX=2. Expected results come from a digit-queue
//               reference model.
// Config      : PAL_REVERSE_OUT_EN - also checks reversed_num when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_palindrome_checker_seq;

  logic        clk;
  logic        rst;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_is_pal;
  logic [15:0] a_in_number;
  logic [2:0]  a_digit_count;
  logic [19:0] a_reversed;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_is_pal;
  logic [7:0]  b_in_number;
  logic [3:0]  b_digit_count;
  logic [8:0]  b_reversed;

  int checks;
  int failures;

  palindrome_checker_seq dut_a (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (a_in_valid),
    .in_ready      (a_in_ready),
    .in_number     (a_in_number),
    .out_valid     (a_out_valid),
    .out_ready     (a_out_ready),
    .is_palindrome (a_is_pal),
    .digit_count   (a_digit_count)
`ifdef PAL_REVERSE_OUT_EN
    ,
    .reversed_num  (a_reversed)
`endif
  );

  palindrome_checker_seq #(
    .WIDTH (8),
    .RADIX (2)
  ) dut_b (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (b_in_valid),
    .in_ready      (b_in_ready),
    .in_number     (b_in_number),
    .out_valid     (b_out_valid),
    .out_ready     (b_out_ready),
    .is_palindrome (b_is_pal),
    .digit_count   (b_digit_count)
`ifdef PAL_REVERSE_OUT_EN
    ,
    .reversed_num  (b_reversed)
`endif
  );

`ifndef PAL_REVERSE_OUT_EN
  assign a_reversed = '0;
  assign b_reversed = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: list the significant digits, then compare the list with
  // its mirror image. The reversed value reads the list back as a number.
  function automatic void ref_model(input longint unsigned n, input int radix,
                                    output int nd, output bit pal,
                                    output longint unsigned rev);
    int unsigned     dq[$];
    longint unsigned v;
    v = n;
    do begin
      dq.push_back(int'(v % 64'(radix)));
      v = v / 64'(radix);
    end while (v != 0);
    nd  = dq.size();
    pal = 1'b1;
    for (int i = 0; i < nd; i++)
      if (dq[i] != dq[nd-1-i]) pal = 1'b0;
    rev = 0;
    foreach (dq[i]) rev = rev * 64'(radix) + 64'(dq[i]);
  endfunction

  // One transaction on A; 'hold' cycles of out_ready=0 with stray inputs.
  task automatic txn_a(input logic [15:0] n, input int hold);
    int nd; bit pal; longint unsigned rev; int lat;
    ref_model(64'(n), 10, nd, pal, rev);
    check_eq("a_idle_ready", 64'(a_in_ready), 1);
    a_in_valid  = 1'b1;
    a_in_number = n;
    @(posedge clk); #1;
    a_in_valid  = 1'b0;
    a_in_number = 16'($urandom);
    check_eq("a_busy_ready", 64'(a_in_ready), 0);
    lat = 0;
    while (!a_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("a_latency", 64'(lat), 64'(nd));
    check_eq("a_is_pal", 64'(a_is_pal), 64'(pal));
    check_eq("a_count", 64'(a_digit_count), 64'(nd));
`ifdef PAL_REVERSE_OUT_EN
    check_eq("a_reversed", 64'(a_reversed), rev);
`endif
    for (int h = 0; h < hold; h++) begin
      a_in_valid  = 1'($urandom);
      a_in_number = 16'($urandom);
      @(posedge clk); #1;
      check_eq("a_hold_valid", 64'(a_out_valid), 1);
      check_eq("a_hold_ready", 64'(a_in_ready), 0);
      check_eq("a_hold_is_pal", 64'(a_is_pal), 64'(pal));
      check_eq("a_hold_count", 64'(a_digit_count), 64'(nd));
`ifdef PAL_REVERSE_OUT_EN
      check_eq("a_hold_reversed", 64'(a_reversed), rev);
`endif
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    check_eq("a_release_valid", 64'(a_out_valid), 0);
    check_eq("a_release_ready", 64'(a_in_ready), 1);
    check_eq("a_idle_is_pal", 64'(a_is_pal), 64'(pal));
  endtask

  task automatic txn_b(input logic [7:0] n);
    int nd; bit pal; longint unsigned rev; int lat;
    ref_model(64'(n), 2, nd, pal, rev);
    b_in_valid  = 1'b1;
    b_in_number = n;
    @(posedge clk); #1;
    b_in_valid  = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("b_latency", 64'(lat), 64'(nd));
    check_eq("b_is_pal", 64'(b_is_pal), 64'(pal));
    check_eq("b_count", 64'(b_digit_count), 64'(nd));
`ifdef PAL_REVERSE_OUT_EN
    check_eq("b_reversed", 64'(b_reversed), rev);
`endif
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    check_eq("b_release_valid", 64'(b_out_valid), 0);
  endtask

  // Back-to-back stream on B with a scoreboard of accepted numbers.
  task automatic stream_b(input int n_items);
    logic [7:0] sb[$];
    int sent, done, cyc, nd; bit pal; longint unsigned rev; logic [7:0] n;
    sent = 0; done = 0; cyc = 0;
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    b_in_number = 8'($urandom);
    while (done < n_items && cyc < 2000) begin
      if (b_out_valid && b_out_ready) begin
        if (sb.size() == 0) begin
          check_eq("b_stream_spurious", 64'(b_out_valid), 0);
        end else begin
          n = sb.pop_front();
          ref_model(64'(n), 2, nd, pal, rev);
          check_eq("b_stream_is_pal", 64'(b_is_pal), 64'(pal));
          check_eq("b_stream_count", 64'(b_digit_count), 64'(nd));
`ifdef PAL_REVERSE_OUT_EN
          check_eq("b_stream_reversed", 64'(b_reversed), rev);
`endif
        end
        done++;
      end
      if (b_in_valid && b_in_ready) begin
        sb.push_back(b_in_number);
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
      b_in_number = 8'($urandom);
      if (sent >= n_items) b_in_valid = 1'b0;
    end
    check_eq("b_stream_done", 64'(done), 64'(n_items));
    b_in_valid  = 1'b0;
    b_out_ready = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] dir_a [8];
    checks = 0; failures = 0;
    rst = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_number = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_number = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_a_in_ready", 64'(a_in_ready), 1);
    check_eq("rst_a_out_valid", 64'(a_out_valid), 0);
    check_eq("rst_a_is_pal", 64'(a_is_pal), 0);
    check_eq("rst_a_count", 64'(a_digit_count), 0);
    check_eq("rst_a_reversed", 64'(a_reversed), 0);
    check_eq("rst_b_in_ready", 64'(b_in_ready), 1);
    check_eq("rst_b_out_valid", 64'(b_out_valid), 0);
    rst = 1'b0;

    // Directed radix-10 cases including the reversed-width boundary.
    dir_a = '{16'd12321, 16'd12345, 16'd0, 16'd10,
              16'd59999, 16'd59995, 16'd65456, 16'd65535};
    foreach (dir_a[i]) txn_a(dir_a[i], 0);

    // Result held while the consumer stalls; stray inputs ignored.
    txn_a(16'd12321, 3);
    txn_a(16'd4004, 2);

    // Reset in the middle of RUN aborts the operation.
    a_in_valid  = 1'b1;
    a_in_number = 16'd12321;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("midrst_in_ready", 64'(a_in_ready), 1);
    check_eq("midrst_out_valid", 64'(a_out_valid), 0);
    check_eq("midrst_is_pal", 64'(a_is_pal), 0);
    check_eq("midrst_count", 64'(a_digit_count), 0);
    txn_a(16'd7, 0);

    // Randomized radix-10 traffic with random stalls.
    repeat (30) txn_a(16'($urandom), int'($urandom_range(0, 2)));

    // Radix 2, 8-bit instance.
    txn_b(8'd9);
    txn_b(8'd10);
    txn_b(8'd255);
    txn_b(8'd0);
    txn_b(8'd128);
    stream_b(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
